// File: rtl/shift_register_nonblocking_pkg.sv
// +------------------------------------------------------------------+
// | shift_register_nonblocking_pkg: depth limits and stage vector     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package shift_register_nonblocking_pkg;

  localparam int DEPTH_DEFAULT = 2;
  localparam int DEPTH_MAX     = 32;

  typedef logic [DEPTH_MAX-1:0] sr_vec_t;

endpackage

`default_nettype wire

// File: rtl/shift_register_nonblocking_sr_stage.sv
// +------------------------------------------------------------------+
// | sr_stage: one D flop, sync active-high reset to 0, load enable    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module sr_stage (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_register_nonblocking.sv
// +------------------------------------------------------------------+
// | shift_register_nonblocking: DEPTH-stage serial shift register;    |
// | SHIFT_REG_NB_ENABLE_EN makes a[1] a shift enable. Rev 1.0         |
// +------------------------------------------------------------------+
`default_nettype none

module shift_register_nonblocking
  import shift_register_nonblocking_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT  // legal range 2..DEPTH_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] a,
  output logic       q1,
  output logic       q2
);

  logic [DEPTH-1:0] stages;
  logic             shift_en;

`ifdef SHIFT_REG_NB_ENABLE_EN
  assign shift_en = a[1];
`else
  // a[1] has no function in this build; keep it visibly consumed.
  logic unused_a1;
  assign unused_a1 = a[1];
  assign shift_en  = 1'b1;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic d;
    if (i == 0) begin : g_first
      assign d = a[0];
    end else begin : g_next
      assign d = stages[i-1];
    end

    sr_stage u_stage (
      .clk (clk),
      .rst (rst),
      .en  (shift_en),
      .d   (d),
      .q   (stages[i])
    );
  end

  assign q1 = stages[0];
  assign q2 = stages[DEPTH-1];

endmodule

`default_nettype wire

// File: tb/tb_shift_register_nonblocking.sv
// Directed bench: DEPTH=2 vector table plus hand sequences (mid-cycle input change, enable, DEPTH=4).
`default_nettype none

module tb_shift_register_nonblocking;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] a;
  logic       q1, q2;
  logic       rst4;
  logic [1:0] a4;
  logic       q1_4, q2_4;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  shift_register_nonblocking dut (
    .clk (clk), .rst (rst), .a (a), .q1 (q1), .q2 (q2)
  );

  shift_register_nonblocking #(.DEPTH(4)) dut4 (
    .clk (clk), .rst (rst4), .a (a4), .q1 (q1_4), .q2 (q2_4)
  );

  typedef struct {
    logic       rst;
    logic [1:0] a;
    logic       q1;
    logic       q2;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Drive at negedge, let one posedge happen, sample 1ns later.
  task automatic step2(input logic r, input logic [1:0] av, input logic e1, input logic e2,
                       input string name);
    @(negedge clk);
    rst = r;
    a   = av;
    @(posedge clk);
    #1;
    check({name, ".q1"}, q1, e1);
    check({name, ".q2"}, q2, e2);
  endtask

  task automatic step4(input logic r, input logic a0, input logic e1, input logic e2,
                       input string name);
    @(negedge clk);
    rst4 = r;
    a4   = {1'b1, a0};
    @(posedge clk);
    #1;
    check({name, ".q1"}, q1_4, e1);
    check({name, ".q2"}, q2_4, e2);
  endtask

  initial begin
    rst  = 1'b1;
    a    = 2'b11;
    rst4 = 1'b1;
    a4   = 2'b10;

    //               rst   a      q1    q2
    vecs[0]  = '{1'b1, 2'b11, 1'b0, 1'b0};  // reset
    vecs[1]  = '{1'b1, 2'b11, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 2'b11, 1'b0, 1'b0};  // reset held
    vecs[3]  = '{1'b0, 2'b00, 1'b0, 1'b0};  // release
    vecs[4]  = '{1'b0, 2'b11, 1'b1, 1'b0};  // basic shift
    vecs[5]  = '{1'b0, 2'b10, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 2'b11, 1'b1, 1'b0};  // walking 1,0,1,1,0
    vecs[7]  = '{1'b0, 2'b10, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 2'b11, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 2'b11, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 2'b10, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 2'b11, 1'b1, 1'b0};  // load q1=q2=1
    vecs[12] = '{1'b0, 2'b11, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 2'b11, 1'b0, 1'b0};  // mid-operation reset
    vecs[14] = '{1'b0, 2'b11, 1'b1, 1'b0};  // restart captures a[0]
    vecs[15] = '{1'b0, 2'b10, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 2'b10, 1'b0, 1'b0};

    for (int i = 0; i < 17; i++) begin
      step2(vecs[i].rst, vecs[i].a, vecs[i].q1, vecs[i].q2, $sformatf("vec%0d", i));
    end

    // Input changes mid-cycle: only the value present at the edge is captured.
    @(negedge clk);
    a = 2'b10;
    #2;
    a = 2'b11;
    @(posedge clk);
    #1;
    check("midcycle.q1", q1, 1'b1);
    check("midcycle.q2", q2, 1'b0);
    a = 2'b10;
    #2;
    check("midcycle_noflow.q1", q1, 1'b1);
    step2(1'b0, 2'b10, 1'b0, 1'b1, "midcycle_next");
    step2(1'b0, 2'b10, 1'b0, 1'b0, "drain");

`ifdef SHIFT_REG_NB_ENABLE_EN
    step2(1'b0, 2'b11, 1'b1, 1'b0, "en_load");
    for (int k = 0; k < 3; k++) begin
      step2(1'b0, 2'b00, 1'b1, 1'b0, $sformatf("en_hold%0d", k));
    end
    step2(1'b0, 2'b10, 1'b0, 1'b1, "en_resume");
    step2(1'b1, 2'b00, 1'b0, 1'b0, "en_rst_while_hold");
`else
    step2(1'b0, 2'b01, 1'b1, 1'b0, "a1_ignored0");
    step2(1'b0, 2'b00, 1'b0, 1'b1, "a1_ignored1");
    step2(1'b0, 2'b01, 1'b1, 1'b0, "a1_ignored2");
`endif

    // DEPTH=4: single pulse reaches q1 after 1 edge, q2 after 4 edges.
    step4(1'b1, 1'b0, 1'b0, 1'b0, "d4_rst0");
    step4(1'b1, 1'b0, 1'b0, 1'b0, "d4_rst1");
    step4(1'b0, 1'b1, 1'b1, 1'b0, "d4_e1");
    step4(1'b0, 1'b0, 1'b0, 1'b0, "d4_e2");
    step4(1'b0, 1'b0, 1'b0, 1'b0, "d4_e3");
    step4(1'b0, 1'b0, 1'b0, 1'b1, "d4_e4");
    step4(1'b0, 1'b0, 1'b0, 1'b0, "d4_e5");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, expected finish before 100us");
    $fatal(1);
  end

endmodule

`default_nettype wire
